dmem_arbiter: RTL

- Sequences and shares the single-port data memory (DataMem) between two requesters.
- Port A is the pipeline load/store unit; port B is a secondary master (debug/DMA loader).
- Drives DataMem's Mem_Addr/Mem_rd/Mem_wr/Mem_DIN and waits out its fixed read delay.
- Returns read data, or a write completion, with a one-cycle ACK to the winning requester.

---
 rtl/dmem_arb_pkg.sv | 22 ++
 rtl/dmem_arb_pick.sv | 40 ++++
 rtl/dmem_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the DataMem arbiter: FSM states, requester IDs, default sizes.
// No logic; imported by dmem_arb_pick and dmem_arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } st_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MEM_SIZE = 1024;
    localparam int DEF_RD_LAT   = 2;

endpackage

// File: rtl/dmem_arb_pick.sv
// Requester selector: one-hot grant and owner ID, fixed A priority or round-robin (DMEM_ARB_RR_EN).
// Latency: combinational grant, 0 cycles; the round-robin pointer updates on the granting edge.
// Backpressure: grants only while enabled (arbiter IDLE); a losing requester simply waits.
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       a_req,
    input  logic       b_req,
    input  logic       en,
    output logic [1:0] gnt,
    output req_id_t    id
);

    logic pick_b;

`ifdef DMEM_ARB_RR_EN
    // last_b set means B was granted most recently, so A wins the next tie.
    logic last_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b <= 1'b1;
        end else if (|gnt) begin
            last_b <= pick_b;
        end
    end

    assign pick_b = b_req & (~a_req | ~last_b);
`else
    assign pick_b = b_req & ~a_req;
`endif

    assign id  = pick_b ? REQ_B : REQ_A;
    assign gnt = en ? {b_req & pick_b, a_req & ~pick_b} : 2'b00;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port DataMem between port A (LSU) and port B (debug/DMA); RR arbitration with DMEM_ARB_RR_EN.
// Latency GNT to ACK: read RD_LAT+1, write 2, address error 1 cycle; at least one IDLE cycle between ACK and GNT.
// Backpressure: requesters hold REQ and payload until GNT; only one transaction is in flight at a time.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MEM_SIZE = DEF_MEM_SIZE,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic              A_GNT,
    output logic              A_ACK,
    output logic              A_ERR,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_GNT,
    output logic              B_ACK,
    output logic              B_ERR,
    output logic [DATA_W-1:0] B_RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RD,
    output logic              MEM_WR,
    output logic [DATA_W-1:0] MEM_DIN,
    input  logic [DATA_W-1:0] MEM_DOUT
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    st_t               state, nxt;
    req_id_t           owner, pick_id;
    logic [1:0]        gnt;
    logic              err_q;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_bad;

    dmem_arb_pick u_pick (
`ifdef DMEM_ARB_RR_EN
        .clk   (CLK),
        .rst_n (RST_N),
`endif
        .a_req (A_REQ),
        .b_req (B_REQ),
        .en    (state == ST_IDLE),
        .gnt   (gnt),
        .id    (pick_id)
    );

    assign sel_addr  = (pick_id == REQ_B) ? B_ADDR  : A_ADDR;
    assign sel_wdata = (pick_id == REQ_B) ? B_WDATA : A_WDATA;
    assign sel_we    = (pick_id == REQ_B) ? B_WE    : A_WE;
    assign sel_bad   = (sel_addr[1:0] != 2'b00) || ((sel_addr >> 2) >= ADDR_W'(MEM_SIZE));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt    = state;
        MEM_RD = 1'b0;
        MEM_WR = 1'b0;
        A_GNT  = gnt[0];
        B_GNT  = gnt[1];
        A_ACK  = 1'b0;
        B_ACK  = 1'b0;
        A_ERR  = 1'b0;
        B_ERR  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|gnt) begin
                    nxt = sel_bad ? ST_RESP : (sel_we ? ST_WR : ST_RD);
                end
            end
            ST_RD: begin
                MEM_RD = 1'b1;
                if (cnt == '0) begin
                    nxt = ST_RESP;
                end
            end
            ST_WR: begin
                // One full cycle high, so it spans the negedge where DataMem commits.
                MEM_WR = 1'b1;
                nxt    = ST_RESP;
            end
            ST_RESP: begin
                A_ACK = (owner == REQ_A);
                B_ACK = (owner == REQ_B);
                A_ERR = (owner == REQ_A) & err_q;
                B_ERR = (owner == REQ_B) & err_q;
                nxt   = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner    <= REQ_A;
            err_q    <= 1'b0;
            cnt      <= '0;
            MEM_ADDR <= '0;
            MEM_DIN  <= '0;
            A_RDATA  <= '0;
            B_RDATA  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner <= pick_id;
                        err_q <= sel_bad;
                        cnt   <= CNT_W'(RD_LAT - 1);
                        // A rejected address leaves the memory bus untouched.
                        if (!sel_bad) begin
                            MEM_ADDR <= sel_addr;
                            if (sel_we) begin
                                MEM_DIN <= sel_wdata;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (cnt == '0) begin
                        if (owner == REQ_A) begin
                            A_RDATA <= MEM_DOUT;
                        end else begin
                            B_RDATA <= MEM_DOUT;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
